// File: rtl/bcu_pkg.sv
// Shared types and helpers for the bit-count unit: operation encoding,
// FSM states and the result-width function.
package bcu_pkg;

    typedef enum logic [1:0] {
        MODE_POPCNT  = 2'b00,
        MODE_HAMMING = 2'b01,
        MODE_CLZ     = 2'b10,
        MODE_CTZ     = 2'b11
    } bcu_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } bcu_state_e;

    // Bits needed to hold a count from 0 up to and including w.
    function automatic int bcu_cw(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bcu_chunk_count.sv
// Combinational per-chunk counters: popcount, leading/trailing zeros, any-one.
module bcu_chunk_count #(
    parameter  int CHUNK = 8,
    localparam int CCW   = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] data,
    output logic [CCW-1:0]   popcnt,
    output logic [CCW-1:0]   lzc,
    output logic [CCW-1:0]   tzc,
    output logic             any_one
);

    logic seen_hi;
    logic seen_lo;

    always_comb begin
        popcnt  = '0;
        lzc     = '0;
        tzc     = '0;
        seen_hi = 1'b0;
        seen_lo = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            popcnt = popcnt + CCW'(data[i]);
            if (!seen_hi && !data[CHUNK-1-i]) lzc = lzc + CCW'(1);
            if (data[CHUNK-1-i]) seen_hi = 1'b1;
            if (!seen_lo && !data[i]) tzc = tzc + CCW'(1);
            if (data[i]) seen_lo = 1'b1;
        end
        any_one = |data;
    end

endmodule

// File: rtl/bit_count_unit.sv
// Multi-cycle POPCNT / HAMMING / CLZ / CTZ unit that walks the operand
// CHUNK bits per cycle with a fixed, data-independent latency.
module bit_count_unit
    import bcu_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int CHUNK = 8,
    localparam int CW    = bcu_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    result,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CCW    = $clog2(CHUNK + 1);

    bcu_state_e       state_q, state_d;
    bcu_mode_e        mode_q, mode_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic             found_q, found_d;
    logic [CW-1:0]    result_q, result_d;

    logic [CHUNK-1:0] chunk;
    logic [CCW-1:0]   c_pop, c_lz, c_tz;
    logic             c_any;
    logic             last_chunk;

    // The operand register shifts so the chunk under test is always at one end.
    assign chunk      = (mode_q == MODE_CLZ) ? opnd_q[WIDTH-1 -: CHUNK] : opnd_q[CHUNK-1:0];
    assign last_chunk = (cnt_q == CNTW'(NCHUNK - 1));

    bcu_chunk_count #(.CHUNK(CHUNK)) u_chunk (
        .data    (chunk),
        .popcnt  (c_pop),
        .lzc     (c_lz),
        .tzc     (c_tz),
        .any_one (c_any)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)   state_d = ST_RUN;
            ST_RUN:  if (last_chunk) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        result    = result_q;
    end

    always_comb begin
        mode_d   = mode_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        found_d  = found_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mode_d  = bcu_mode_e'(mode);
                    opnd_d  = (bcu_mode_e'(mode) == MODE_HAMMING) ? (src1 ^ src2) : src1;
                    cnt_d   = '0;
                    acc_d   = '0;
                    found_d = 1'b0;
                end
            end
            ST_RUN: begin
                opnd_d = (mode_q == MODE_CLZ) ? (opnd_q << CHUNK) : (opnd_q >> CHUNK);
                cnt_d  = cnt_q + CNTW'(1);
                if (mode_q == MODE_POPCNT || mode_q == MODE_HAMMING) begin
                    acc_d = acc_q + CW'(c_pop);
                end else if (!found_q) begin
                    acc_d   = acc_q + ((mode_q == MODE_CLZ) ? CW'(c_lz) : CW'(c_tz));
                    found_d = c_any;
                end
                if (last_chunk) result_d = acc_d;
            end
            ST_DONE: begin
                if (out_ready) result_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_POPCNT;
            opnd_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            found_q  <= 1'b0;
            result_q <= '0;
        end else begin
            mode_q   <= mode_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            found_q  <= found_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_bit_count_unit.sv
// Bench for bit_count_unit: directed table at WIDTH=32, stall and reset
// sequences, and random operands at WIDTH=16/CHUNK=4 against a reference.
module tb_bit_count_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit / CHUNK=8 instance
    logic        iv32, rdy32, ov32, ordy32, busy32;
    logic [1:0]  md32;
    logic [31:0] a32, b32;
    logic [5:0]  res32;

    // 16-bit / CHUNK=4 instance
    logic        iv16, rdy16, ov16, ordy16, busy16;
    logic [1:0]  md16;
    logic [15:0] a16, b16;
    logic [4:0]  res16;

    bit_count_unit u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32), .mode(md32),
        .src1(a32), .src2(b32), .out_valid(ov32), .out_ready(ordy32),
        .result(res32), .busy(busy32)
    );

    bit_count_unit #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .mode(md16),
        .src1(a16), .src2(b16), .out_valid(ov16), .out_ready(ordy16),
        .result(res16), .busy(busy16)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: counts straight from the definition of each operation.
    function automatic int ref_count(input int w, input logic [1:0] m,
                                     input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        int n;
        x = (m == 2'b01) ? (a ^ b) : a;
        n = 0;
        case (m)
            2'b00, 2'b01: for (int i = 0; i < w; i++) n += int'(x[i]);
            2'b10: begin
                for (int i = w - 1; i >= 0; i--) begin
                    if (x[i]) break;
                    n++;
                end
            end
            default: begin
                for (int i = 0; i < w; i++) begin
                    if (x[i]) break;
                    n++;
                end
            end
        endcase
        return n;
    endfunction

    function automatic int cur_res(input bit w16);
        return w16 ? int'(res16) : int'(res32);
    endfunction

    // One full transaction; hold = cycles out_ready stays low in DONE.
    task automatic run_op(input bit w16, input logic [1:0] m, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          output int res, output int lat);
        int first;
        @(negedge clk);
        chk("in_ready_idle", w16 ? rdy16 : rdy32, 1);
        if (w16) begin iv16 = 1'b1; md16 = m; a16 = a[15:0]; b16 = b[15:0]; end
        else     begin iv32 = 1'b1; md32 = m; a32 = a;       b32 = b;       end
        @(posedge clk);
        @(negedge clk);
        // scramble inputs so any late sampling corrupts the result
        iv16 = 1'b0; iv32 = 1'b0;
        a32 = $urandom; b32 = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
        md32 = 2'($urandom); md16 = 2'($urandom);
        chk("busy_run", w16 ? busy16 : busy32, 1);
        chk("result_zero_run", cur_res(w16), 0);
        lat = 0;
        while (!(w16 ? ov16 : ov32) && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) chk("in_ready_run", w16 ? rdy16 : rdy32, 0);
        end
        if (lat >= 20) chk("out_valid_timeout", lat, -1);
        res = cur_res(w16);
        first = res;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_out_valid", w16 ? ov16 : ov32, 1);
            chk("stall_result", cur_res(w16), first);
            chk("stall_in_ready", w16 ? rdy16 : rdy32, 0);
        end
        if (w16) ordy16 = 1'b1; else ordy32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy16 = 1'b0; ordy32 = 1'b0;
        chk("post_in_ready", w16 ? rdy16 : rdy32, 1);
        chk("post_out_valid", w16 ? ov16 : ov32, 0);
        chk("post_result", cur_res(w16), 0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] s1;
        logic [31:0] s2;
        int          exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int r, l;
        vecs[0]  = '{2'b00, 32'hF0F0_0001, 32'h0, 9};
        vecs[1]  = '{2'b01, 32'hFFFF_0000, 32'h0000_FFFF, 32};
        vecs[2]  = '{2'b01, 32'h1234_5678, 32'h1234_5678, 0};
        vecs[3]  = '{2'b10, 32'h0001_0000, 32'h0, 15};
        vecs[4]  = '{2'b11, 32'h0001_0000, 32'h0, 16};
        vecs[5]  = '{2'b10, 32'h0, 32'hFFFF_FFFF, 32};
        vecs[6]  = '{2'b11, 32'h0, 32'hFFFF_FFFF, 32};
        vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 32'h0, 32};
        vecs[8]  = '{2'b10, 32'h8000_0000, 32'h0, 0};
        vecs[9]  = '{2'b11, 32'h0000_0001, 32'h0, 0};
        vecs[10] = '{2'b10, 32'h00FF_0001, 32'h0, 8};
        vecs[11] = '{2'b11, 32'h8000_0000, 32'h0, 31};

        iv32 = 0; md32 = 0; a32 = 0; b32 = 0; ordy32 = 0;
        iv16 = 0; md16 = 0; a16 = 0; b16 = 0; ordy16 = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", rdy32, 1);
        chk("rst_out_valid", ov32, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_result", res32, 0);
        chk("rst_in_ready16", rdy16, 0 + 1);

        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].mode, vecs[i].s1, vecs[i].s2, 0, r, l);
            chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), l, 4);
        end

        // stall in DONE
        run_op(1'b0, 2'b10, 32'h0001_0000, 32'h0, 5, r, l);
        chk("stall_op_result", r, 15);

        // reset in the 2nd RUN cycle
        @(negedge clk);
        iv32 = 1'b1; md32 = 2'b00; a32 = 32'hFFFF_FFFF; b32 = 32'h0;
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_in_ready", rdy32, 1);
        chk("midrun_rst_out_valid", ov32, 0);
        chk("midrun_rst_result", res32, 0);
        chk("midrun_rst_busy", busy32, 0);
        run_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0, 0, r, l);
        chk("after_rst_popcnt", r, 32);

        // random operands at WIDTH=16, CHUNK=4
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  m;
            logic [31:0] a, b;
            m = 2'($urandom);
            a = {16'h0, 16'($urandom)};
            b = {16'h0, 16'($urandom)};
            if (i % 8 == 0) a = 32'h0;
            if (i % 8 == 1) a = 32'h0000_FFFF;
            if (i % 4 == 2) a = a & {16'h0, 16'h1 << $urandom_range(15)};
            run_op(1'b1, m, a, b, (i % 10 == 3) ? 2 : 0, r, l);
            chk($sformatf("rnd16_%0d_m%0d_result", i, m), r, ref_count(16, m, a, b));
            chk($sformatf("rnd16_%0d_latency", i), l, 4);
        end

        // random operands at WIDTH=32
        for (int i = 0; i < 20; i++) begin
            logic [1:0]  m;
            logic [31:0] a, b;
            m = 2'($urandom);
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) a = a >> $urandom_range(31);
            run_op(1'b0, m, a, b, 0, r, l);
            chk($sformatf("rnd32_%0d_m%0d_result", i, m), r, ref_count(32, m, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_count_unit.md
BIT_COUNT_UNIT -- requirements
Module: bit_count_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand width in bits, legal values 8..64.
REQ-002 The block SHALL have parameter CHUNK, default 8: bits processed per cycle, must divide WIDTH.
REQ-003 The block SHALL have derived constant CW = clog2(WIDTH+1): result width, 6 at WIDTH=32.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 POPCNT, 01 HAMMING, 10 CLZ, 11 CTZ.
REQ-009 The block SHALL have port src1, input, WIDTH bits: primary operand.
REQ-010 The block SHALL have port src2, input, WIDTH bits: second operand, used by HAMMING only.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port result, output, CW bits: count.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, in_valid and in_ready high at an edge SHALL capture mode, and src1 or src1^src2 for HAMMING, into an operand register; it SHALL clear the accumulator and found-flag, load chunk counter 0, and go to RUN.
REQ-017 RUN SHALL process one CHUNK per cycle: LSB-first for POPCNT, HAMMING and CTZ; MSB-first for CLZ.
REQ-018 POPCNT and HAMMING SHALL add the chunk popcount to the accumulator each RUN cycle.
REQ-019 CLZ and CTZ, while found=0, SHALL add the chunk's leading or trailing zero count; found SHALL set once a chunk contains a 1; no further accumulation SHALL occur after that.
REQ-020 Latency SHALL be fixed and data-independent: out_valid rises exactly WIDTH/CHUNK edges after the accepting edge (4 at defaults); CLZ/CTZ SHALL NOT early-exit.
REQ-021 After the last chunk the FSM SHALL go to DONE; out_valid SHALL be 1 in DONE only.
REQ-022 result SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-023 In DONE with out_ready=1, the FSM SHALL return to IDLE at that edge; a new request SHALL NOT be accepted in the same cycle, so back-to-back throughput is one result per WIDTH/CHUNK+2 cycles.
REQ-024 CLZ/CTZ of a zero operand SHALL return WIDTH; POPCNT of all-ones SHALL return WIDTH without overflow, since CW is sized for that.
REQ-025 in_valid in RUN/DONE SHALL be ignored; inputs SHALL be sampled only at the accepting edge.
REQ-026 result SHALL be 0 outside DONE.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, in_ready=1, out_valid=0, busy=0, result=0, accumulator=0 and found=0, including mid-RUN or in DONE; the in-flight operation SHALL be discarded.
REQ-028 rst SHALL take priority over every handshake event in the same cycle.

Structure
REQ-029 Package bcu_pkg SHALL hold the mode encoding, the FSM state typedef and a clog2-based CW helper function.
REQ-030 Sub-module bcu_chunk_count SHALL be combinational: CHUNK-bit input, outputs popcount, leading-zero count, trailing-zero count and any_one; it SHALL be instantiated once.
REQ-031 The top level SHALL contain the FSM, operand register, chunk counter, accumulator and found flag.

Verification
REQ-032 Apply POPCNT with src1=32'hF0F0_0001 -> result=9, with out_valid 4 edges after accept.
REQ-033 Apply HAMMING with src1=32'hFFFF_0000 and src2=32'h0000_FFFF -> result=32; with src1=src2=32'h1234_5678 -> result=0.
REQ-034 Apply CLZ with src1=32'h0001_0000 -> result=15; CTZ with the same operand -> result=16; CLZ and CTZ with src1=0 -> result=32.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stay stable and in_ready stays 0; then out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-036 Assert rst in the 2nd RUN cycle -> next cycle in IDLE with out_valid=0 and result=0; a subsequent POPCNT of 32'hFFFF_FFFF -> result=32.
REQ-037 Use parameters WIDTH=16 and CHUNK=4 with random operands against a reference model -> all modes match and latency is 4.
